// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the register file with reservation scoreboard.
package regfile_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_REGS = 4;

   typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit array with reservation-conflict detection for the register file.
module rf_scoreboard #(
   parameter int NUM_REGS = 4,
   localparam int ADDR_W = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic                rsv_en_i,
   input  logic [ADDR_W-1:0]   rsv_addr_i,
   output logic [NUM_REGS-1:0] busy_o,
   output logic                rsv_err_o
);

   localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

   logic [NUM_REGS-1:0] busy_q, busy_d, clr_s, set_s;
   logic                err_q, err_d;

   // Next busy state: a write releases its target, a reservation sets it afterwards so it wins.
   always_comb begin
      clr_s  = we_i     ? (ONE_HOT0 << wr_addr_i)  : {NUM_REGS{1'b0}};
      set_s  = rsv_en_i ? (ONE_HOT0 << rsv_addr_i) : {NUM_REGS{1'b0}};
      busy_d = (busy_q & ~clr_s) | set_s;
      err_d  = rsv_en_i && busy_q[rsv_addr_i] && !(we_i && (wr_addr_i == rsv_addr_i));
   end

   // Busy array and error pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= {NUM_REGS{1'b0}};
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_o    = busy_q;
   assign rsv_err_o = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file (1W/2R) with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy-clear to the read ports.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   localparam int ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              busy1,
   output logic              busy2,
   output logic              rsv_err
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_s;

   // Storage next state: only the addressed entry can change.
   always_comb begin
      regs_d          = regs_q;
      regs_d[wr_addr] = we ? wr_data : regs_q[wr_addr];
   end

   // Register storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: {DATA_W{1'b0}}};
      end else begin
         regs_q <= regs_d;
      end
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .we_i       (we),
      .wr_addr_i  (wr_addr),
      .rsv_en_i   (rsv_en),
      .rsv_addr_i (rsv_addr),
      .busy_o     (busy_s),
      .rsv_err_o  (rsv_err)
   );

   // Read muxes, optionally forwarding the in-flight write.
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      if (we && (wr_addr == rd_addr1)) begin
         rd_data1 = wr_data;
         busy1    = 1'b0;
      end else begin
         rd_data1 = regs_q[rd_addr1];
         busy1    = busy_s[rd_addr1];
      end
      if (we && (wr_addr == rd_addr2)) begin
         rd_data2 = wr_data;
         busy2    = 1'b0;
      end else begin
         rd_data2 = regs_q[rd_addr2];
         busy2    = busy_s[rd_addr2];
      end
`else
      rd_data1 = regs_q[rd_addr1];
      busy1    = busy_s[rd_addr1];
      rd_data2 = regs_q[rd_addr2];
      busy2    = busy_s[rd_addr2];
`endif
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard-style bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;
   import regfile_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   logic      we;
   reg_addr_t wr_addr;
   logic [7:0] wr_data;
   reg_addr_t rd_addr1, rd_addr2;
   logic [7:0] rd_data1, rd_data2;
   logic      rsv_en;
   reg_addr_t rsv_addr;
   logic      busy1, busy2, rsv_err;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   regfile_scoreboard dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy1    (busy1),
      .busy2    (busy2),
      .rsv_err  (rsv_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int v);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input string tag, input int obs);
      if (exp_q.size() == 0) check_eq({tag, "_underflow"}, 1, 0);
      else check_eq(tag, obs, exp_q.pop_front());
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      we = 1'b0; rsv_en = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = 8'h00;
      rd_addr1 = '0; rd_addr2 = '0; rsv_en = 1'b0; rsv_addr = '0;
      #12;
      push_exp(0); push_exp(0); push_exp(0);
      pop_check("rst_data", int'(rd_data1));
      pop_check("rst_busy", int'(busy1));
      pop_check("rst_err", int'(rsv_err));
      rst = 1'b0;

      // Writes to r0, r1, then a disabled write to r2
      tick;
      we = 1'b1; wr_addr = 2'd0; wr_data = 8'hAA; tick;
      wr_addr = 2'd1; wr_data = 8'h55; tick;
      we = 1'b0; wr_addr = 2'd2; wr_data = 8'hCC; tick;
      rd_addr1 = 2'd0; rd_addr2 = 2'd1; push_exp(8'hAA); push_exp(8'h55); push_exp(0);
      #1;
      pop_check("wr_r0", int'(rd_data1));
      pop_check("wr_r1", int'(rd_data2));
      pop_check("wr_r0_busy", int'(busy1));
      rd_addr1 = 2'd2; push_exp(8'h00);
      #1 pop_check("nowr_r2", int'(rd_data1));

      // Reserve r3, then release it by writing
      tick;
      rsv_en = 1'b1; rsv_addr = 2'd3; tick;
      idle; rd_addr1 = 2'd3; push_exp(1); push_exp(0);
      #1;
      pop_check("rsv3_busy", int'(busy1));
      pop_check("rsv3_err", int'(rsv_err));
      we = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
`ifdef REGFILE_BYPASS_EN
      push_exp(0);
`else
      push_exp(1);
`endif
      #1 pop_check("wr3_busy_pre", int'(busy1));
      tick;
      idle; push_exp(0); push_exp(8'h77);
      #1;
      pop_check("wr3_busy", int'(busy1));
      pop_check("wr3_data", int'(rd_data1));

      // Double reservation of r2
      rsv_en = 1'b1; rsv_addr = 2'd2; tick;
      push_exp(0); #1 pop_check("rsv2a_err", int'(rsv_err));
      tick;
      idle; rd_addr2 = 2'd2; push_exp(1); push_exp(1);
      #1;
      pop_check("rsv2b_err", int'(rsv_err));
      pop_check("rsv2b_busy", int'(busy2));
      tick;
      push_exp(0); push_exp(1);
      pop_check("rsv2_err_clr", int'(rsv_err));
      pop_check("rsv2_busy_hold", int'(busy2));

      // Reserve and write r1 in the same cycle
      rsv_en = 1'b1; rsv_addr = 2'd1; we = 1'b1; wr_addr = 2'd1; wr_data = 8'h5A; tick;
      idle; rd_addr1 = 2'd1; push_exp(8'h5A); push_exp(1); push_exp(0);
      #1;
      pop_check("rw1_data", int'(rd_data1));
      pop_check("rw1_busy", int'(busy1));
      pop_check("rw1_err", int'(rsv_err));
      // Re-reserve busy r1 while it is being written: no error
      rsv_en = 1'b1; rsv_addr = 2'd1; we = 1'b1; wr_addr = 2'd1; wr_data = 8'h11; tick;
      idle; push_exp(0); push_exp(1); push_exp(8'h11);
      #1;
      pop_check("rw1b_err", int'(rsv_err));
      pop_check("rw1b_busy", int'(busy1));
      pop_check("rw1b_data", int'(rd_data1));

      // Same-cycle write/read of r2 (r2 still busy, holds 00)
      rd_addr2 = 2'd2; we = 1'b1; wr_addr = 2'd2; wr_data = 8'h3C;
`ifdef REGFILE_BYPASS_EN
      push_exp(8'h3C); push_exp(0);
`else
      push_exp(8'h00); push_exp(1);
`endif
      #1;
      pop_check("byp_data", int'(rd_data2));
      pop_check("byp_busy", int'(busy2));
      tick;
      idle; push_exp(8'h3C); push_exp(0);
      #1;
      pop_check("post_wr2_data", int'(rd_data2));
      pop_check("post_wr2_busy", int'(busy2));

      // Mid-run reset with r0 busy and an error pulse pending
      we = 1'b1; wr_addr = 2'd0; wr_data = 8'hAA; rsv_en = 1'b1; rsv_addr = 2'd0; tick;
      we = 1'b0; rsv_addr = 2'd1; tick;
      idle; rd_addr1 = 2'd0; rd_addr2 = 2'd1; push_exp(8'hAA); push_exp(1); push_exp(1);
      pop_check("pre_rst_data", int'(rd_data1));
      pop_check("pre_rst_busy", int'(busy1));
      pop_check("pre_rst_err", int'(rsv_err));
      #1 rst = 1'b1;
      push_exp(0); push_exp(0); push_exp(0); push_exp(0);
      #1;
      pop_check("mid_rst_data", int'(rd_data1));
      pop_check("mid_rst_busy", int'(busy1));
      pop_check("mid_rst_err", int'(rsv_err));
      pop_check("mid_rst_r1", int'(rd_data2));
      // Write and reserve under reset are discarded
      we = 1'b1; wr_addr = 2'd3; wr_data = 8'hFF; rsv_en = 1'b1; rsv_addr = 2'd3;
      rd_addr1 = 2'd3; tick;
      #2 rst = 1'b0;
      push_exp(0); push_exp(0);
      #1;
      pop_check("rst_wr_discard", int'(rd_data1));
      pop_check("rst_rsv_discard", int'(busy1));
      rsv_en = 1'b0; tick;
      idle; push_exp(8'hFF);
      #1 pop_check("first_edge_wr", int'(rd_data1));

      if (exp_q.size() != 0) check_eq("queue_leftover", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
